// File: rtl/fsm_pattern_sequencer_pkg.sv
// Shared encodings for the pattern sequencer and the 2-bit serial Moore target it drives.
package fsm_pattern_sequencer_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } tgt_state_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SHIFT  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/fsm_pattern_sequencer.sv
// Clears the target FSM, shifts a latched pattern into its x_in MSB-first, and
// reports the final target state plus how many post-edge samples landed in S3.
module fsm_pattern_sequencer
    import fsm_pattern_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [1:0]       fsm_state,
    output logic             fsm_x,
    output logic             fsm_rst_n,
    output logic             busy,
    output logic             done,
    output logic [1:0]       final_state,
    output logic [LEN_W-1:0] s3_count
);

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    // Handshake: start is a level request sampled only in IDLE; it is neither
    // acknowledged nor queued while busy. done is a one-cycle strobe, and
    // final_state/s3_count are valid from that cycle until the next accept.

    seq_state_t       state;
    logic [WIDTH-1:0] sh;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_c;
    logic             first;

    always_comb begin
        len_c = (len > WIDTH_L) ? WIDTH_L : len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sh          <= '0;
            len_q       <= '0;
            cnt         <= '0;
            first       <= 1'b0;
            fsm_x       <= 1'b0;
            fsm_rst_n   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            final_state <= 2'b00;
            s3_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fsm_rst_n <= 1'b1;
                    fsm_x     <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        // Left-align so the first bit to apply always sits at the MSB.
                        sh        <= pattern << (WIDTH_L - len_c);
                        len_q     <= len_c;
                        s3_count  <= '0;
                        fsm_rst_n <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    fsm_rst_n <= 1'b1;
                    if (len_q == '0) begin
                        fsm_x <= 1'b0;
                        state <= SETTLE;
                    end else begin
                        fsm_x <= sh[WIDTH-1];
                        sh    <= sh << 1;
                        cnt   <= len_q - 1'b1;
                        first <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The first SHIFT cycle still sees the post-clear S0, not a shifted bit.
                    if (!first && fsm_state == S3) begin
                        s3_count <= s3_count + 1'b1;
                    end
                    first <= 1'b0;
                    if (cnt == '0) begin
                        fsm_x <= 1'b0;
                        state <= SETTLE;
                    end else begin
                        fsm_x <= sh[WIDTH-1];
                        sh    <= sh << 1;
                        cnt   <= cnt - 1'b1;
                    end
                end
                SETTLE: begin
                    if (len_q == '0) begin
                        final_state <= S0;
                    end else begin
                        final_state <= fsm_state;
                        if (fsm_state == S3) begin
                            s3_count <= s3_count + 1'b1;
                        end
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
